// File: rtl/apb_master_bridge.sv
// apb_master_bridge: converts a valid/ready request/response port into
// single APB4 transfers (no pipelining), with a programmable ACCESS timeout.
//
// Ports:
//   clock, resetn                   - rising-edge clock, async active-low reset
//   req_valid/req_ready             - request handshake
//   req_addr/write/wdata/wstrb/prot - request payload
//   rsp_valid/rsp_ready             - response handshake
//   rsp_rdata/rsp_err/rsp_timeout   - response payload
//   out_p*                          - APB requester signals (all registered)
//   out_pready/prdata/pslverr       - APB completer signals
module apb_master_bridge #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [ADDR_W-1:0]     req_addr,
    input  logic                  req_write,
    input  logic [DATA_W-1:0]     req_wdata,
    input  logic [DATA_W/8-1:0]   req_wstrb,
    input  logic [2:0]            req_prot,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_W-1:0]     rsp_rdata,
    output logic                  rsp_err,
    output logic                  rsp_timeout,
    output logic [ADDR_W-1:0]     out_paddr,
    output logic                  out_psel,
    output logic                  out_penable,
    output logic [2:0]            out_pprot,
    output logic                  out_pwrite,
    output logic [DATA_W-1:0]     out_pwdata,
    output logic [DATA_W/8-1:0]   out_pstrb,
    input  logic                  out_pready,
    input  logic [DATA_W-1:0]     out_prdata,
    input  logic                  out_pslverr
);

    localparam int unsigned STRB_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    state_t              state_q,     state_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic                req_ready_q, req_ready_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q,   rsp_err_d;
    logic                rsp_tmo_q,   rsp_tmo_d;
    logic [ADDR_W-1:0]   paddr_q,     paddr_d;
    logic                psel_q,      psel_d;
    logic                penable_q,   penable_d;
    logic [2:0]          pprot_q,     pprot_d;
    logic                pwrite_q,    pwrite_d;
    logic [DATA_W-1:0]   pwdata_q,    pwdata_d;
    logic [STRB_W-1:0]   pstrb_q,     pstrb_d;

    logic timeout_hit;

    // Limit is checked on the registered count, so pready in the limit cycle still wins.
    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_W'(TIMEOUT));

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        req_ready_d = req_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        rsp_tmo_d   = rsp_tmo_q;
        paddr_d     = paddr_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pprot_d     = pprot_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        pstrb_d     = pstrb_q;

        case (state_q)
            S_IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid && req_ready_q) begin
                    state_d     = S_SETUP;
                    req_ready_d = 1'b0;
                    cnt_d       = '0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    paddr_d     = req_addr;
                    pwrite_d    = req_write;
                    pwdata_d    = req_wdata;
                    pprot_d     = req_prot;
                    pstrb_d     = req_write ? req_wstrb : '0;
                end
            end
            S_SETUP: begin
                state_d   = S_ACCESS;
                penable_d = 1'b1;
            end
            S_ACCESS: begin
                if (out_pready) begin
                    state_d     = S_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pstrb_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = pwrite_q ? '0 : out_prdata;
                    rsp_err_d   = out_pslverr;
                    rsp_tmo_d   = 1'b0;
                end else if (timeout_hit) begin
                    state_d     = S_RESP;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    pstrb_d     = '0;
                    rsp_valid_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_err_d   = 1'b1;
                    rsp_tmo_d   = 1'b1;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b0;
                    req_ready_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_tmo_q   <= 1'b0;
            paddr_q     <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pprot_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            pstrb_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            rsp_tmo_q   <= rsp_tmo_d;
            paddr_q     <= paddr_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pprot_q     <= pprot_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            pstrb_q     <= pstrb_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_tmo_q;
    assign out_paddr   = paddr_q;
    assign out_psel    = psel_q;
    assign out_penable = penable_q;
    assign out_pprot   = pprot_q;
    assign out_pwrite  = pwrite_q;
    assign out_pwdata  = pwdata_q;
    assign out_pstrb   = pstrb_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Testbench for apb_master_bridge: directed plus randomized transfers, each
// checked cycle by cycle against a transfer-level timing/value model.
module tb_apb_master_bridge;

    localparam int T = 4;

    logic        clock;
    logic        resetn;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic [2:0]  req_prot;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] out_paddr;
    logic        out_psel;
    logic        out_penable;
    logic [2:0]  out_pprot;
    logic        out_pwrite;
    logic [31:0] out_pwdata;
    logic [3:0]  out_pstrb;
    logic        out_pready;
    logic [31:0] out_prdata;
    logic        out_pslverr;

    apb_master_bridge #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T)) dut (
        .clock(clock), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .req_prot(req_prot),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .out_paddr(out_paddr), .out_psel(out_psel), .out_penable(out_penable),
        .out_pprot(out_pprot), .out_pwrite(out_pwrite), .out_pwdata(out_pwdata),
        .out_pstrb(out_pstrb), .out_pready(out_pready), .out_prdata(out_prdata),
        .out_pslverr(out_pslverr)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [2:0]  prot;
        int          waits;   // ACCESS cycles before responder raises pready
        logic [31:0] prdata;
        logic        slverr;
        int          rdly;    // RESP cycles before consumer raises rsp_ready
        bit          b2b;     // present the following request during this one
    } xfer_t;

    int    total = 0;
    int    bad   = 0;
    int    xid   = 0;
    xfer_t cur;
    xfer_t nxt;
    xfer_t q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic xfer_t mk(logic [31:0] a, logic w, logic [31:0] wd, logic [3:0] st,
                                 logic [2:0] pr, int wt, logic [31:0] rd, logic se,
                                 int rl, bit bb);
        xfer_t x;
        x.addr = a; x.write = w; x.wdata = wd; x.wstrb = st; x.prot = pr;
        x.waits = wt; x.prdata = rd; x.slverr = se; x.rdly = rl; x.b2b = bb;
        return x;
    endfunction

    function automatic xfer_t rnd();
        return mk($urandom, 1'($urandom), $urandom, 4'($urandom), 3'($urandom),
                  int'($urandom_range(0, 6)), $urandom, 1'($urandom_range(0, 3) == 0),
                  int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
    endfunction

    task automatic drive_req(input xfer_t x);
        req_valid = 1'b1;
        req_addr  = x.addr;
        req_write = x.write;
        req_wdata = x.wdata;
        req_wstrb = x.wstrb;
        req_prot  = x.prot;
    endtask

    // One transfer, starting and ending at a negedge; model: SETUP at cycle 1,
    // ACCESS for min(waits,T)+1 cycles, then RESP until rsp_ready is taken.
    task automatic run_xfer();
        int  n;
        int  d;
        int  i;
        bit  tmo;
        bit  e_sel;
        bit  e_en;
        bit  e_rv;
        logic [31:0] e_rdata;
        string p;
        n       = (cur.waits > T) ? T : cur.waits;
        tmo     = cur.waits > T;
        d       = cur.rdly;
        e_rdata = (cur.write || tmo) ? 32'h0 : cur.prdata;
        p       = $sformatf("x%0d", xid);
        drive_req(cur);
        for (int w = 0; w < 20 && !req_ready; w++) @(negedge clock);
        chk({p, ".accept_ready"}, 32'(req_ready), 32'd1);
        @(posedge clock);
        for (int k = 1; k <= 4 + n + d; k++) begin
            @(negedge clock);
            if (k == 1) begin
                if (cur.b2b) drive_req(nxt);
                else req_valid = 1'b0;
            end
            e_sel = (k <= 2 + n);
            e_en  = (k >= 2) && (k <= 2 + n);
            e_rv  = (k >= 3 + n) && (k <= 3 + n + d);
            chk($sformatf("%s.psel@%0d", p, k),    32'(out_psel),    32'(e_sel));
            chk($sformatf("%s.penable@%0d", p, k), 32'(out_penable), 32'(e_en));
            chk($sformatf("%s.pstrb@%0d", p, k),   32'(out_pstrb),
                (e_sel && cur.write) ? 32'(cur.wstrb) : 32'h0);
            chk($sformatf("%s.paddr@%0d", p, k),   out_paddr,        cur.addr);
            chk($sformatf("%s.pwrite@%0d", p, k),  32'(out_pwrite),  32'(cur.write));
            chk($sformatf("%s.pwdata@%0d", p, k),  out_pwdata,       cur.wdata);
            chk($sformatf("%s.pprot@%0d", p, k),   32'(out_pprot),   32'(cur.prot));
            chk($sformatf("%s.req_ready@%0d", p, k), 32'(req_ready), 32'(k == 4 + n + d));
            chk($sformatf("%s.rsp_valid@%0d", p, k), 32'(rsp_valid), 32'(e_rv));
            if (e_rv) begin
                chk($sformatf("%s.rdata@%0d", p, k),   rsp_rdata,         e_rdata);
                chk($sformatf("%s.err@%0d", p, k),     32'(rsp_err),      32'(tmo || cur.slverr));
                chk($sformatf("%s.timeout@%0d", p, k), 32'(rsp_timeout),  32'(tmo));
            end
            // Responder: pready from ACCESS index 'waits' onward (late pready after
            // an abort is ignored); prdata/pslverr are junk except on that index.
            i = k - 2;
            out_pready = (k >= 2) && (i >= cur.waits) && (k < 4 + n + d);
            if (k >= 2 && i == cur.waits) begin
                out_prdata  = cur.prdata;
                out_pslverr = cur.slverr;
            end else begin
                out_prdata  = $urandom;
                out_pslverr = 1'($urandom);
            end
            rsp_ready = (k >= 3 + n + d) && (k < 4 + n + d);
        end
        xid++;
    endtask

    task automatic run_queue();
        for (int j = 0; j < q.size(); j++) begin
            cur = q[j];
            if (j + 1 < q.size()) nxt = q[j + 1];
            else cur.b2b = 1'b0;
            run_xfer();
        end
        q.delete();
    endtask

    // Reset asserted while the bridge waits in ACCESS.
    task automatic reset_mid_access();
        cur = mk(32'h2000_0040, 1'b0, 32'h0, 4'hF, 3'd1, 10, 32'hDEAD_BEEF, 1'b0, 0, 1'b0);
        drive_req(cur);
        for (int w = 0; w < 20 && !req_ready; w++) @(negedge clock);
        chk("rst.accept_ready", 32'(req_ready), 32'd1);
        @(posedge clock);
        @(negedge clock);
        req_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        chk("rst.penable_before", 32'(out_penable), 32'd1);
        #2 resetn = 1'b0;
        #1;
        chk("rst.psel_now",    32'(out_psel),    32'd0);
        chk("rst.penable_now", 32'(out_penable), 32'd0);
        chk("rst.rsp_valid",   32'(rsp_valid),   32'd0);
        chk("rst.req_ready",   32'(req_ready),   32'd0);
        chk("rst.paddr",       out_paddr,        32'h0);
        out_pready = 1'b0;
        @(negedge clock);
        @(negedge clock);
        resetn = 1'b1;
        chk("rst.ready_at_release", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("rst.ready_one_edge", 32'(req_ready), 32'd1);
        for (int c = 0; c < 6; c++) begin
            out_pready = 1'b1;
            @(negedge clock);
            chk($sformatf("rst.no_rsp@%0d", c),  32'(rsp_valid), 32'd0);
            chk($sformatf("rst.no_psel@%0d", c), 32'(out_psel),  32'd0);
        end
        out_pready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
        req_wdata = '0; req_wstrb = '0; req_prot = '0; rsp_ready = 1'b0;
        out_pready = 1'b0; out_prdata = '0; out_pslverr = 1'b0;
        #12;
        chk("reset.req_ready",   32'(req_ready),   32'd0);
        chk("reset.rsp_valid",   32'(rsp_valid),   32'd0);
        chk("reset.psel",        32'(out_psel),    32'd0);
        chk("reset.penable",     32'(out_penable), 32'd0);
        chk("reset.paddr",       out_paddr,        32'h0);
        chk("reset.pwdata",      out_pwdata,       32'h0);
        chk("reset.pstrb",       32'(out_pstrb),   32'h0);
        chk("reset.rsp_err",     32'(rsp_err),     32'd0);
        @(negedge clock);
        resetn = 1'b1;
        chk("reset.ready_at_release", 32'(req_ready), 32'd0);
        @(negedge clock);
        chk("reset.ready_first_edge", 32'(req_ready), 32'd1);

        // Directed: zero-wait write, 3-wait read, slave error, limit-cycle pready,
        // timeout with late pready, back-pressure with a queued second request.
        q.push_back(mk(32'h1000_2008, 1'b1, 32'h1234_5678, 4'hF, 3'd0, 0, 32'hFFFF_FFFF, 1'b0, 0, 1'b0));
        q.push_back(mk(32'h1000_2010, 1'b0, 32'h0BAD_0BAD, 4'hF, 3'd2, 3, 32'h0000_A5A5, 1'b0, 0, 1'b0));
        q.push_back(mk(32'h1000_2FFC, 1'b0, 32'h0,         4'h3, 3'd0, 1, 32'h1111_2222, 1'b1, 0, 1'b0));
        q.push_back(mk(32'h1000_3000, 1'b0, 32'h0,         4'h0, 3'd5, T, 32'hCAFE_F00D, 1'b0, 0, 1'b0));
        q.push_back(mk(32'h1000_3004, 1'b0, 32'h0,         4'h0, 3'd0, T + 1, 32'h5555_AAAA, 1'b0, 1, 1'b0));
        q.push_back(mk(32'h1000_3008, 1'b1, 32'hA1B2_C3D4, 4'h9, 3'd7, 2, 32'h7777_7777, 1'b0, 5, 1'b1));
        q.push_back(mk(32'h1000_300C, 1'b1, 32'h0F0F_0F0F, 4'h6, 3'd3, 0, 32'h0,         1'b1, 0, 1'b0));
        for (int r = 0; r < 30; r++) q.push_back(rnd());
        run_queue();

        reset_mid_access();

        for (int r = 0; r < 12; r++) q.push_back(rnd());
        run_queue();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
